// File: rtl/fec_decoder_wimax_phy.sv
// fec_decoder_wimax_phy: hard-decision, tail-biting Viterbi decoder for the
// rate-1/2, K=7 code (G1=171 for X, G2=133 for Y). It collects one coded
// block (X1 Y1 X2 Y2 ...), runs two wrap-around ACS passes over it, traces
// back from the best end state and streams the decoded bits in original order.
// Build option: define FEC_DECODER_METRIC_EN to add the best_metric output
// (bit-error count of the chosen path).
module fec_decoder_wimax_phy #(
    parameter int unsigned DATA_BITS = 96,
    parameter int unsigned METRIC_W  = 8
) (
    input  logic                clk_100,
    input  logic                reset_N,
    input  logic                deinterleaver_output_valid,
    input  logic                data_in,
    input  logic                derandomizer_ready,
    output logic                ready_out,
    output logic                valid_out,
    output logic                data_out
`ifdef FEC_DECODER_METRIC_EN
    ,
    output logic [METRIC_W-1:0] best_metric
`endif
);

    localparam int unsigned CODED_BITS = 2 * DATA_BITS;
    localparam int unsigned STEP_W     = $clog2(DATA_BITS);
    localparam int unsigned CODED_W    = STEP_W + 1;
    localparam int unsigned ST_W       = 6;
    localparam int unsigned NUM_STATES = 1 << ST_W;

    localparam logic [STEP_W-1:0]  LAST_STEP = STEP_W'(DATA_BITS - 1);
    localparam logic [CODED_W-1:0] LAST_BIT  = CODED_W'(CODED_BITS - 1);

    typedef enum logic [2:0] {
        S_COLLECT,
        S_PASS1,
        S_PASS2,
        S_SELECT,
        S_TRACE,
        S_FINISH,
        S_OUTPUT
    } state_t;

    state_t                r_state;
    logic [CODED_W-1:0]    r_bit_cnt;
    logic [STEP_W-1:0]     r_step;
    logic [ST_W-1:0]       r_tb_state;
    logic [DATA_BITS-1:0]  r_obuf;
    logic [CODED_BITS-1:0] r_ibuf;
    logic [METRIC_W-1:0]   r_pm [NUM_STATES];
    logic [NUM_STATES-1:0] r_surv [DATA_BITS];

`ifdef FEC_DECODER_METRIC_EN
    logic [METRIC_W-1:0]   r_pm_start [NUM_STATES];
    logic [METRIC_W-1:0]   r_err;
`endif

    logic                  w_x;
    logic                  w_y;
    logic [METRIC_W-1:0]   w_pm_new [NUM_STATES];
    logic [NUM_STATES-1:0] w_dec;
    logic [ST_W-1:0]       w_best_idx;
    logic [METRIC_W-1:0]   w_best_m;
    logic [METRIC_W-1:0]   w_sel_diff;
    logic                  w_tb_dec;
    logic [STEP_W-1:0]     w_step_inc;
    logic [STEP_W-1:0]     w_step_dec;

    assign w_x        = r_ibuf[{r_step, 1'b0}];
    assign w_y        = r_ibuf[{r_step, 1'b1}];
    assign w_tb_dec   = r_surv[r_step][r_tb_state];
    assign w_step_inc = r_step + STEP_W'(1);
    assign w_step_dec = r_step - STEP_W'(1);

    // One add-compare-select unit per next state n; predecessors are {n[4:0], d}
    for (genvar g = 0; g < NUM_STATES; g++) begin : g_acs
        localparam logic [ST_W-1:0] N   = ST_W'(g);
        localparam int unsigned     P0  = (2 * g) % NUM_STATES;
        localparam int unsigned     P1  = P0 + 1;
        // Expected X/Y for the d=0 branch; d feeds both outputs so d=1 inverts both
        localparam logic            EX0 = N[5] ^ N[4] ^ N[3] ^ N[2];
        localparam logic            EY0 = N[5] ^ N[3] ^ N[2] ^ N[0];
        localparam logic            EX1 = ~EX0;
        localparam logic            EY1 = ~EY0;

        logic [1:0]          w_bm0;
        logic [1:0]          w_bm1;
        logic [METRIC_W-1:0] w_m0;
        logic [METRIC_W-1:0] w_m1;
        logic [METRIC_W-1:0] w_diff;

        assign w_bm0  = {1'b0, EX0 ^ w_x} + {1'b0, EY0 ^ w_y};
        assign w_bm1  = {1'b0, EX1 ^ w_x} + {1'b0, EY1 ^ w_y};
        assign w_m0   = r_pm[P0] + METRIC_W'(w_bm0);
        assign w_m1   = r_pm[P1] + METRIC_W'(w_bm1);
        // Modulo compare: d=1 only when m1 is strictly smaller, so ties keep d=0
        assign w_diff = w_m0 - w_m1;
        assign w_dec[g]    = (w_diff != '0) && !w_diff[METRIC_W-1];
        assign w_pm_new[g] = w_dec[g] ? w_m1 : w_m0;
    end

    // Minimum-metric state search, modulo compare, lowest index wins a tie
    always_comb begin
        w_best_idx = '0;
        w_best_m   = r_pm[0];
        w_sel_diff = '0;
        for (int i = 1; i < NUM_STATES; i++) begin
            w_sel_diff = r_pm[i] - w_best_m;
            if (w_sel_diff[METRIC_W-1]) begin
                w_best_idx = ST_W'(i);
                w_best_m   = r_pm[i];
            end
        end
    end

    // Coded-bit buffer and survivor decision memory (contents need no reset)
    always_ff @(posedge clk_100) begin
        if (r_state == S_COLLECT && ready_out && deinterleaver_output_valid) begin
            r_ibuf[r_bit_cnt] <= data_in;
        end
        if (r_state == S_PASS2) begin
            r_surv[r_step] <= w_dec;
        end
    end

    // Control FSM, path metrics, traceback and output stream
    always_ff @(posedge clk_100 or negedge reset_N) begin
        if (!reset_N) begin
            r_state     <= S_COLLECT;
            r_bit_cnt   <= '0;
            r_step      <= '0;
            r_tb_state  <= '0;
            r_obuf      <= '0;
            r_pm        <= '{default: '0};
            ready_out   <= 1'b0;
            valid_out   <= 1'b0;
            data_out    <= 1'b0;
`ifdef FEC_DECODER_METRIC_EN
            r_pm_start  <= '{default: '0};
            r_err       <= '0;
            best_metric <= '0;
`endif
        end else begin
            case (r_state)
                S_COLLECT: begin
                    ready_out <= 1'b1;
                    if (ready_out && deinterleaver_output_valid) begin
                        if (r_bit_cnt == LAST_BIT) begin
                            r_bit_cnt <= '0;
                            ready_out <= 1'b0;
                            r_state   <= S_PASS1;
                        end else begin
                            r_bit_cnt <= r_bit_cnt + CODED_W'(1);
                        end
                    end
                end
                S_PASS1: begin
                    r_pm <= w_pm_new;
                    if (r_step == LAST_STEP) begin
                        r_step  <= '0;
                        r_state <= S_PASS2;
`ifdef FEC_DECODER_METRIC_EN
                        r_pm_start <= w_pm_new;
`endif
                    end else begin
                        r_step <= w_step_inc;
                    end
                end
                S_PASS2: begin
                    r_pm <= w_pm_new;
                    if (r_step == LAST_STEP) begin
                        r_step  <= '0;
                        r_state <= S_SELECT;
                    end else begin
                        r_step <= w_step_inc;
                    end
                end
                S_SELECT: begin
                    r_tb_state <= w_best_idx;
                    r_step     <= LAST_STEP;
                    r_state    <= S_TRACE;
`ifdef FEC_DECODER_METRIC_EN
                    r_err      <= w_best_m - r_pm_start[w_best_idx];
`endif
                end
                S_TRACE: begin
                    r_obuf[r_step] <= r_tb_state[ST_W-1];
                    r_tb_state     <= {r_tb_state[ST_W-2:0], w_tb_dec};
                    if (r_step == '0) begin
                        r_state <= S_FINISH;
                    end else begin
                        r_step <= w_step_dec;
                    end
                end
                S_FINISH: begin
                    valid_out <= 1'b1;
                    data_out  <= r_obuf[0];
                    r_step    <= '0;
                    r_state   <= S_OUTPUT;
`ifdef FEC_DECODER_METRIC_EN
                    best_metric <= r_err;
`endif
                end
                S_OUTPUT: begin
                    if (derandomizer_ready) begin
                        if (r_step == LAST_STEP) begin
                            valid_out <= 1'b0;
                            data_out  <= 1'b0;
                            ready_out <= 1'b1;
                            r_step    <= '0;
                            r_pm      <= '{default: '0};
                            r_state   <= S_COLLECT;
                        end else begin
                            r_step   <= w_step_inc;
                            data_out <= r_obuf[w_step_inc];
                        end
                    end
                end
                default: begin
                    r_state <= S_COLLECT;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fec_decoder_wimax_phy.sv
// Testbench for fec_decoder_wimax_phy: blocks are encoded by a reference
// tail-biting convolutional encoder, fed to the decoder, and the decoded
// stream is checked against a queue of expected message bits.
module tb_fec_decoder_wimax_phy;

    localparam int          LATENCY = 290;
    localparam logic [6:0]  G1      = 7'o171;
    localparam logic [6:0]  G2      = 7'o133;
    localparam logic [95:0] MSG_REF = 96'hACBCD2114DAE1577C6DBF4C9;

    logic clk_100;
    logic reset_N;
    logic deinterleaver_output_valid;
    logic data_in;
    logic derandomizer_ready;
    logic ready_out;
    logic valid_out;
    logic data_out;
`ifdef FEC_DECODER_METRIC_EN
    logic [7:0] best_metric;
`endif

    int   n_cmp;
    int   n_bad;
    logic exp_q[$];
    logic got_q[$];

    fec_decoder_wimax_phy dut (
        .clk_100                    (clk_100),
        .reset_N                    (reset_N),
        .deinterleaver_output_valid (deinterleaver_output_valid),
        .data_in                    (data_in),
        .derandomizer_ready         (derandomizer_ready),
        .ready_out                  (ready_out),
        .valid_out                  (valid_out),
        .data_out                   (data_out)
`ifdef FEC_DECODER_METRIC_EN
        ,
        .best_metric                (best_metric)
`endif
    );

    always #5 clk_100 = ~clk_100;

    // Reference encoder: window {u, d1..d6}, register preloaded with the last six inputs
    function automatic logic [191:0] encode(input logic [95:0] msg);
        logic [5:0]   hist;
        logic [6:0]   win;
        logic [191:0] cw;
        logic         u;
        for (int j = 0; j < 6; j++) hist[5-j] = msg[j];
        cw = '0;
        for (int k = 0; k < 96; k++) begin
            u    = msg[95-k];
            win  = {u, hist};
            cw[191-2*k] = ^(win & G1);
            cw[190-2*k] = ^(win & G2);
            hist = {u, hist[5:1]};
        end
        return cw;
    endfunction

    task automatic push_msg(input logic [95:0] msg);
        for (int k = 0; k < 96; k++) exp_q.push_back(msg[95-k]);
    endtask

    // Drive one coded block, optionally with idle gaps; returns at #1 after the last accepting edge
    task automatic feed(input logic [191:0] cw, input bit gaps, output bit ok);
        int budget;
        ok = 1'b1;
        for (int p = 0; p < 192; p++) begin
            if (gaps && $urandom_range(0, 2) == 0) begin
                deinterleaver_output_valid = 1'b0;
                data_in = 1'($urandom);
                @(posedge clk_100); #1;
            end
            deinterleaver_output_valid = 1'b1;
            data_in = cw[191-p];
            budget = 0;
            @(negedge clk_100);
            while (!ready_out && budget < 1000) begin
                @(negedge clk_100);
                budget++;
            end
            if (!ready_out) begin
                ok = 1'b0;
                break;
            end
            @(posedge clk_100); #1;
        end
        deinterleaver_output_valid = 1'b0;
    endtask

    // Observe the output stream; mode 1 stalls 2 of every 3 cycles, garbage drives junk valids
    task automatic collect(input int mode, input bit garbage, output int lat, output int nx,
                           output int stall_bad, output int stalls, output int rdy_hi, output bit tmo);
        int   cyc;
        bit   stalled;
        logic held;
        cyc = 0; stalled = 1'b0; held = 1'b0;
        lat = -1; nx = 0; stall_bad = 0; stalls = 0; rdy_hi = 0;
        while (nx < 96 && cyc < 3000) begin
            derandomizer_ready = (mode == 0) ? 1'b1 : (cyc % 3 == 0);
            if (garbage) begin
                deinterleaver_output_valid = 1'b1;
                data_in = 1'($urandom);
            end
            @(negedge clk_100);
            if (stalled && (valid_out !== 1'b1 || data_out !== held)) stall_bad++;
            if (ready_out === 1'b1) rdy_hi++;
            if (valid_out === 1'b1 && lat < 0) lat = cyc;
            if (valid_out === 1'b1 && derandomizer_ready) begin
                got_q.push_back(data_out);
                nx++;
                stalled = 1'b0;
            end else if (valid_out === 1'b1) begin
                stalled = 1'b1;
                held = data_out;
                stalls++;
            end else begin
                stalled = 1'b0;
            end
            @(posedge clk_100); #1;
            cyc++;
        end
        tmo = (nx < 96);
        deinterleaver_output_valid = 1'b0;
        derandomizer_ready = 1'b1;
    endtask

    task automatic test_reset();
        reset_N = 1'b0;
        deinterleaver_output_valid = 1'b0;
        data_in = 1'b0;
        derandomizer_ready = 1'b1;
        repeat (3) @(posedge clk_100);
        #1;
        n_cmp++;
        if ({ready_out, valid_out, data_out} !== 3'b000) begin
            n_bad++;
            $display("FAIL reset_outputs: got rdy/vld/dat=%b%b%b want 000", ready_out, valid_out, data_out);
        end
`ifdef FEC_DECODER_METRIC_EN
        n_cmp++;
        if (best_metric !== 8'd0) begin
            n_bad++;
            $display("FAIL reset_best_metric: got %0d want 0", best_metric);
        end
`endif
        @(negedge clk_100);
        reset_N = 1'b1;
        #1;
        n_cmp++;
        if (ready_out !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_ready_early: got %b want 0", ready_out);
        end
        @(posedge clk_100); #1;
        n_cmp++;
        if (ready_out !== 1'b1) begin
            n_bad++;
            $display("FAIL reset_ready_rise: got %b want 1", ready_out);
        end
    endtask

    // Shared body for single-block scenarios: err_pos < 0 means no channel error
    task automatic test_block(input string name, input logic [95:0] msg, input int err_pos,
                              input bit gaps, input int mode, input int exp_metric);
        logic [191:0] cw;
        bit           ok, tmo;
        int           lat, nx, sb, st, rh, i;
        logic         g, e;
        cw = encode(msg);
        if (err_pos >= 0) cw[191-err_pos] = ~cw[191-err_pos];
        push_msg(msg);
        feed(cw, gaps, ok);
        n_cmp++;
        if (!ok) begin
            n_bad++;
            $display("FAIL %s_feed: ready_out never rose within budget", name);
        end
        collect(mode, 1'b0, lat, nx, sb, st, rh, tmo);
        n_cmp++;
        if (tmo) begin
            n_bad++;
            $display("FAIL %s_timeout: got %0d transfers want 96", name, nx);
        end
        n_cmp++;
        if (lat != LATENCY) begin
            n_bad++;
            $display("FAIL %s_latency: got %0d want %0d", name, lat, LATENCY);
        end
        if (mode != 0) begin
            n_cmp++;
            if (sb != 0 || st == 0) begin
                n_bad++;
                $display("FAIL %s_stall_hold: got %0d unstable of %0d stalls want 0 unstable", name, sb, st);
            end
        end
        i = 0;
        while (got_q.size() > 0 && exp_q.size() > 0) begin
            g = got_q.pop_front();
            e = exp_q.pop_front();
            n_cmp++;
            if (g !== e) begin
                n_bad++;
                $display("FAIL %s_bit%0d: got %b want %b", name, i, g, e);
            end
            i++;
        end
        n_cmp++;
        if (exp_q.size() != 0 || got_q.size() != 0) begin
            n_bad++;
            $display("FAIL %s_count: leftover got %0d expected %0d", name, got_q.size(), exp_q.size());
        end
        exp_q.delete();
        got_q.delete();
        @(negedge clk_100);
        n_cmp++;
        if (valid_out !== 1'b0 || ready_out !== 1'b1) begin
            n_bad++;
            $display("FAIL %s_end: got vld=%b rdy=%b want vld=0 rdy=1", name, valid_out, ready_out);
        end
`ifdef FEC_DECODER_METRIC_EN
        n_cmp++;
        if (best_metric !== 8'(exp_metric)) begin
            n_bad++;
            $display("FAIL %s_best_metric: got %0d want %0d", name, best_metric, exp_metric);
        end
`else
        if (exp_metric < 0) $display("note: negative metric expectation ignored");
`endif
        @(posedge clk_100); #1;
    endtask

    task automatic test_clean();
        test_block("clean", MSG_REF, -1, 1'b0, 0, 0);
    endtask

    task automatic test_single_error();
        test_block("single_err", MSG_REF, 100, 1'b0, 0, 1);
    endtask

    task automatic test_all_zero();
        test_block("all_zero", 96'h0, -1, 1'b0, 0, 0);
    endtask

    task automatic test_backpressure();
        test_block("backpressure", MSG_REF, -1, 1'b1, 1, 0);
    endtask

    // Four blocks in a row with junk valids driven while the decoder is busy
    task automatic test_back_to_back();
        logic [95:0]  msg;
        logic [191:0] cw;
        bit           ok, tmo;
        int           lat, nx, sb, st, rh, i;
        logic         g, e;
        for (int b = 0; b < 4; b++) begin
            msg = {$urandom, $urandom, $urandom};
            cw  = encode(msg);
            push_msg(msg);
            feed(cw, 1'b0, ok);
            n_cmp++;
            if (!ok) begin
                n_bad++;
                $display("FAIL b2b%0d_feed: ready_out never rose within budget", b);
            end
            collect(0, 1'b1, lat, nx, sb, st, rh, tmo);
            n_cmp++;
            if (tmo || lat != LATENCY) begin
                n_bad++;
                $display("FAIL b2b%0d_timing: got %0d transfers latency %0d want 96 / %0d", b, nx, lat, LATENCY);
            end
            n_cmp++;
            if (rh != 0) begin
                n_bad++;
                $display("FAIL b2b%0d_ready_low: got %0d cycles with ready_out=1 want 0", b, rh);
            end
            i = 0;
            while (got_q.size() > 0 && exp_q.size() > 0) begin
                g = got_q.pop_front();
                e = exp_q.pop_front();
                n_cmp++;
                if (g !== e) begin
                    n_bad++;
                    $display("FAIL b2b%0d_bit%0d: got %b want %b", b, i, g, e);
                end
                i++;
            end
            n_cmp++;
            if (exp_q.size() != 0 || got_q.size() != 0) begin
                n_bad++;
                $display("FAIL b2b%0d_count: leftover got %0d expected %0d", b, got_q.size(), exp_q.size());
            end
            exp_q.delete();
            got_q.delete();
        end
    endtask

    // Reset in PASS2 and in OUTPUT, then a fresh block must decode
    task automatic test_reset_mid();
        bit ok;
        int cnt;
        push_msg(MSG_REF);
        feed(encode(MSG_REF), 1'b0, ok);
        repeat (140) @(posedge clk_100);
        #2 reset_N = 1'b0;
        #1;
        n_cmp++;
        if ({ready_out, valid_out, data_out} !== 3'b000) begin
            n_bad++;
            $display("FAIL rst_pass2: got rdy/vld/dat=%b%b%b want 000", ready_out, valid_out, data_out);
        end
        exp_q.delete();
        got_q.delete();
        @(negedge clk_100);
        reset_N = 1'b1;
        @(posedge clk_100); #1;

        derandomizer_ready = 1'b0;
        feed(encode(MSG_REF), 1'b0, ok);
        cnt = 0;
        @(negedge clk_100);
        while (valid_out !== 1'b1 && cnt < 400) begin
            @(negedge clk_100);
            cnt++;
        end
        n_cmp++;
        if (valid_out !== 1'b1 || data_out !== MSG_REF[95]) begin
            n_bad++;
            $display("FAIL rst_out_pre: got vld=%b dat=%b want vld=1 dat=%b", valid_out, data_out, MSG_REF[95]);
        end
        @(posedge clk_100);
        #2 reset_N = 1'b0;
        #1;
        n_cmp++;
        if ({ready_out, valid_out, data_out} !== 3'b000) begin
            n_bad++;
            $display("FAIL rst_output: got rdy/vld/dat=%b%b%b want 000", ready_out, valid_out, data_out);
        end
`ifdef FEC_DECODER_METRIC_EN
        n_cmp++;
        if (best_metric !== 8'd0) begin
            n_bad++;
            $display("FAIL rst_best_metric: got %0d want 0", best_metric);
        end
`endif
        derandomizer_ready = 1'b1;
        @(negedge clk_100);
        reset_N = 1'b1;
        @(posedge clk_100); #1;
        test_block("after_reset", MSG_REF, -1, 1'b0, 0, 0);
    endtask

    initial begin
        clk_100 = 1'b0;
        n_cmp = 0;
        n_bad = 0;
        test_reset();
        test_clean();
        test_single_error();
        test_all_zero();
        test_backpressure();
        test_back_to_back();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
